// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_pkg
//  Description : Shared types, field widths, FSM encoding and pitch table
//                for the note sequencer.
//  Revision    : 1.0
// ============================================================================
package note_pkg;

    localparam int PITCH_W = 5;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = PITCH_W + DUR_W;
    localparam int HP_W    = 18;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY  = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } entry_t;

    // Equal-tempered half-periods at 100 MHz; code 1 = C4, code 10 = A4, code 0 = rest.
    localparam logic [HP_W-1:0] PITCH_LUT [32] = '{
        18'd0,      18'd191113, 18'd180386, 18'd170262,
        18'd160706, 18'd151686, 18'd143173, 18'd135137,
        18'd127553, 18'd120394, 18'd113636, 18'd107258,
        18'd101238, 18'd95556,  18'd90193,  18'd85131,
        18'd80353,  18'd75843,  18'd71586,  18'd67569,
        18'd63776,  18'd60197,  18'd56818,  18'd53629,
        18'd50619,  18'd47778,  18'd45097,  18'd42566,
        18'd40177,  18'd37922,  18'd35793,  18'd33784
    };

endpackage
`default_nettype wire

// File: rtl/note_rom.sv
`default_nettype none
// ============================================================================
//  Module      : note_rom
//  Description : Song storage, ROM_DEPTH x 9-bit entries, one-cycle read.
//  Revision    : 1.0
// ============================================================================
module note_rom
    import note_pkg::*;
#(
    parameter int                           ROM_DEPTH = 64,
    parameter int                           ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] SONG      = '0
) (
    input  logic              clk_in,
    input  logic [ADDR_W-1:0] addr,
    output entry_t            rdata
);

    entry_t rom_words [ROM_DEPTH];
    entry_t rdata_d;
    entry_t rdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            assign rom_words[gi] = SONG[gi*ENTRY_W +: ENTRY_W];
        end
    endgenerate

    always_comb begin
        rdata_d = rom_words[addr];
    end

    always_ff @(posedge clk_in) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Steps through a song ROM on beat ticks and drives a tone
//                divider with per-note half-periods.
//  Revision    : 1.0
// ============================================================================
module note_sequencer
    import note_pkg::*;
#(
    parameter int                           ROM_DEPTH = 64,
    parameter bit                           LOOP      = 1'b0,
    parameter logic [ROM_DEPTH*ENTRY_W-1:0] SONG      = '0,
    localparam int                          ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              beat_tick,
    input  logic              play,
    input  logic              stop,
    output logic [HP_W-1:0]   tone_half_period,
    output logic              tone_en,
    output logic [ADDR_W-1:0] note_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

    state_t             state_d,    state_q;
    logic               fetch_ph_d, fetch_ph_q;
    logic [ADDR_W-1:0]  note_idx_d, note_idx_q;
    logic [PITCH_W-1:0] pitch_d,    pitch_q;
    logic [DUR_W-1:0]   dur_d,      dur_q;
    logic [DUR_W-1:0]   beat_cnt_d, beat_cnt_q;
    logic [HP_W-1:0]    tone_half_period_d, tone_half_period_q;
    logic               tone_en_d,  tone_en_q;
    logic               busy_d,     busy_q;
    logic               done_d,     done_q;
    entry_t             rom_data;

    note_rom #(
        .ROM_DEPTH (ROM_DEPTH),
        .ADDR_W    (ADDR_W),
        .SONG      (SONG)
    ) u_rom (
        .clk_in (clk_in),
        .addr   (note_idx_q),
        .rdata  (rom_data)
    );

    always_comb begin
        state_d            = state_q;
        fetch_ph_d         = fetch_ph_q;
        note_idx_d         = note_idx_q;
        pitch_d            = pitch_q;
        dur_d              = dur_q;
        beat_cnt_d         = beat_cnt_q;
        tone_half_period_d = tone_half_period_q;

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        state_d    = ST_FETCH;
                        note_idx_d = '0;
                        fetch_ph_d = 1'b0;
                    end
                end
                ST_FETCH: begin
                    // First cycle presents the address; the ROM word is valid in the second.
                    if (!fetch_ph_q) begin
                        fetch_ph_d = 1'b1;
                    end else begin
                        fetch_ph_d = 1'b0;
                        pitch_d    = rom_data.pitch;
                        dur_d      = rom_data.dur;
                        if (rom_data.dur == '0) begin
                            if (LOOP) begin
                                note_idx_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            state_d            = ST_PLAY;
                            beat_cnt_d         = '0;
                            tone_half_period_d = PITCH_LUT[rom_data.pitch];
                        end
                    end
                end
                ST_PLAY: begin
                    if (beat_tick) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (beat_cnt_q == dur_q - 1'b1) begin
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (beat_tick) begin
                        fetch_ph_d = 1'b0;
                        if (note_idx_q == LAST_IDX) begin
                            if (LOOP) begin
                                note_idx_d = '0;
                                state_d    = ST_FETCH;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            note_idx_d = note_idx_q + 1'b1;
                            state_d    = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change only on the clock edge.
        tone_en_d = (state_d == ST_PLAY) && (pitch_d != '0);
        busy_d    = (state_d == ST_FETCH) || (state_d == ST_PLAY) || (state_d == ST_GAP);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            fetch_ph_q         <= 1'b0;
            note_idx_q         <= '0;
            pitch_q            <= '0;
            dur_q              <= '0;
            beat_cnt_q         <= '0;
            tone_half_period_q <= '0;
            tone_en_q          <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            fetch_ph_q         <= fetch_ph_d;
            note_idx_q         <= note_idx_d;
            pitch_q            <= pitch_d;
            dur_q              <= dur_d;
            beat_cnt_q         <= beat_cnt_d;
            tone_half_period_q <= tone_half_period_d;
            tone_en_q          <= tone_en_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
        end
    end

    assign tone_half_period = tone_half_period_q;
    assign tone_en          = tone_en_q;
    assign note_idx         = note_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
`default_nettype wire
